// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: load funct3 codes, the buffered
// entry record and the round-robin pointer width helper.
package wb_pkg;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  // Entry fields are sized for the widest supported configuration; narrower
  // builds zero-extend into them and read back only the low bits.
  localparam int XLEN_MAX = 64;
  localparam int RD_W_MAX = 8;

  typedef struct packed {
    logic [XLEN_MAX-1:0] data;
    logic [RD_W_MAX-1:0] rd;
    logic                fp;
    logic                load;
    logic [2:0]          funct3;
    logic [1:0]          offset;
  } wb_entry_t;

  function automatic int rr_ptr_w(input int n_src);
    return (n_src > 1) ? $clog2(n_src) : 1;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load alignment: byte/half/word extraction at the given lane
// with sign or zero extension; non-loads and unknown funct3 pass unchanged.
module wb_load_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] din,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic            load,
  output logic [XLEN-1:0] dout
);
  import wb_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = din[7:0];
      2'd1:    byte_sel = din[15:8];
      2'd2:    byte_sel = din[23:16];
      default: byte_sel = din[31:24];
    endcase
    half_sel = offset[1] ? din[31:16] : din[15:0];
    word_sel = din[31:0];
  end

  always_comb begin
    dout = din;
    if (load) begin
      case (funct3)
        FNC_LB:  dout = XLEN'($signed(byte_sel));
        FNC_LH:  dout = XLEN'($signed(half_sel));
        FNC_LW:  dout = XLEN'($signed(word_sel));
        FNC_LBU: dout = XLEN'(byte_sel);
        FNC_LHU: dout = XLEN'(half_sel);
        default: dout = din;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback merge: per-source one-entry buffers drained round-robin into a
// registered register-file write port. WB_LOAD_ALIGN_EN enables load alignment.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int N_SRC = 4,
  parameter int RD_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [N_SRC-1:0]      src_valid,
  output logic [N_SRC-1:0]      src_ready,
  input  logic [N_SRC*XLEN-1:0] src_data,
  input  logic [N_SRC*RD_W-1:0] src_rd,
  input  logic [N_SRC-1:0]      src_fp,
  input  logic [N_SRC-1:0]      src_load,
  input  logic [N_SRC*3-1:0]    src_funct3,
  input  logic [N_SRC*2-1:0]    src_offset,
  output logic                  wb_regwen,
  output logic                  wb_fpregwen,
  output logic [RD_W-1:0]       wb_rd,
  output logic [XLEN-1:0]       wb_wdata,
  output logic                  wb_busy
);
  import wb_pkg::*;

  localparam int PTR_W = rr_ptr_w(N_SRC);

  logic [N_SRC-1:0] buf_v;
  logic [N_SRC-1:0] grant;
  logic [N_SRC-1:0] accept;
  wb_entry_t        buf_q [N_SRC];
  wb_entry_t        new_e [N_SRC];

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_next;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] cand_idx;
  logic             gnt_v;
  int               cand;

  logic [XLEN-1:0]  sel_data;
  logic [XLEN-1:0]  aligned;
  logic [RD_W-1:0]  sel_rd;
  logic             sel_fp;

  // First occupied buffer at or after rr_ptr, wrapping at N_SRC.
  always_comb begin
    gnt_v    = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_SRC) cand = cand - N_SRC;
      cand_idx = PTR_W'(cand);
      if (!gnt_v && buf_v[cand_idx]) begin
        gnt_v   = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  assign rr_next   = (gnt_idx == PTR_W'(N_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);
  assign grant     = (flush || !gnt_v) ? '0 : (N_SRC'(1) << gnt_idx);
  assign src_ready = flush ? '0 : (~buf_v | grant);
  assign accept    = src_valid & src_ready;
  assign wb_busy   = |buf_v;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      new_e[i]      = '0;
      new_e[i].data = XLEN_MAX'(src_data[i*XLEN +: XLEN]);
      new_e[i].rd   = RD_W_MAX'(src_rd[i*RD_W +: RD_W]);
      new_e[i].fp   = src_fp[i];
`ifdef WB_LOAD_ALIGN_EN
      new_e[i].load   = src_load[i];
      new_e[i].funct3 = src_funct3[i*3 +: 3];
      new_e[i].offset = src_offset[i*2 +: 2];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v <= '0;
      for (int i = 0; i < N_SRC; i++) buf_q[i] <= '0;
    end else if (flush) begin
      buf_v <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (accept[i]) begin
          buf_v[i] <= 1'b1;
          buf_q[i] <= new_e[i];
        end else if (grant[i]) begin
          buf_v[i] <= 1'b0;
        end
      end
    end
  end

  assign sel_data = buf_q[gnt_idx].data[XLEN-1:0];
  assign sel_rd   = buf_q[gnt_idx].rd[RD_W-1:0];
  assign sel_fp   = buf_q[gnt_idx].fp;

`ifdef WB_LOAD_ALIGN_EN
  wb_load_align #(.XLEN(XLEN)) u_load_align (
    .din    (sel_data),
    .funct3 (buf_q[gnt_idx].funct3),
    .offset (buf_q[gnt_idx].offset),
    .load   (buf_q[gnt_idx].load),
    .dout   (aligned)
  );
`else
  // Producers deliver pre-aligned data; the load controls are don't-cares.
  logic unused_load_ctrl;
  assign unused_load_ctrl = ^{src_load, src_funct3, src_offset};
  assign aligned = sel_data;
`endif

  // Integer writes to x0 still consume the entry but never raise the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_regwen   <= 1'b0;
      wb_fpregwen <= 1'b0;
      wb_rd       <= '0;
      wb_wdata    <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      wb_regwen   <= 1'b0;
      wb_fpregwen <= 1'b0;
    end else if (gnt_v) begin
      wb_regwen   <= !sel_fp && (sel_rd != '0);
      wb_fpregwen <= sel_fp;
      wb_rd       <= sel_rd;
      wb_wdata    <= aligned;
      rr_ptr      <= rr_next;
    end else begin
      wb_regwen   <= 1'b0;
      wb_fpregwen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table of single-entry writes plus
// hand sequences for contention, async reset, single-source streaming and flush.
module tb_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int N_SRC = 4;
  localparam int RD_W  = 5;

`ifdef WB_LOAD_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic [N_SRC-1:0]      src_valid;
  logic [N_SRC-1:0]      src_ready;
  logic [N_SRC*XLEN-1:0] src_data;
  logic [N_SRC*RD_W-1:0] src_rd;
  logic [N_SRC-1:0]      src_fp;
  logic [N_SRC-1:0]      src_load;
  logic [N_SRC*3-1:0]    src_funct3;
  logic [N_SRC*2-1:0]    src_offset;
  logic                  wb_regwen;
  logic                  wb_fpregwen;
  logic [RD_W-1:0]       wb_rd;
  logic [XLEN-1:0]       wb_wdata;
  logic                  wb_busy;

  wb_arbiter #(.XLEN(XLEN), .N_SRC(N_SRC), .RD_W(RD_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_data    (src_data),
    .src_rd      (src_rd),
    .src_fp      (src_fp),
    .src_load    (src_load),
    .src_funct3  (src_funct3),
    .src_offset  (src_offset),
    .wb_regwen   (wb_regwen),
    .wb_fpregwen (wb_fpregwen),
    .wb_rd       (wb_rd),
    .wb_wdata    (wb_wdata),
    .wb_busy     (wb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fp;
    logic        ld;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic        exp_wen;
    logic        exp_fwen;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [31:0] d, input logic [4:0] rd,
                         input logic fp, input logic ld, input logic [2:0] f3,
                         input logic [1:0] off);
    src_data[i*XLEN +: XLEN] = d;
    src_rd[i*RD_W +: RD_W]   = rd;
    src_fp[i]                = fp;
    src_load[i]              = ld;
    src_funct3[i*3 +: 3]     = f3;
    src_offset[i*2 +: 2]     = off;
  endtask

  task automatic add_vec(input int s, input logic [31:0] d, input logic [4:0] rd,
                         input logic fp, input logic ld, input logic [2:0] f3,
                         input logic [1:0] off, input logic wen, input logic fwen,
                         input logic [31:0] aligned_exp);
    vec_t v;
    v.src = s; v.data = d; v.rd = rd; v.fp = fp; v.ld = ld; v.f3 = f3; v.off = off;
    v.exp_wen = wen; v.exp_fwen = fwen;
    v.exp_wdata = ALIGN ? aligned_exp : d;
    vq.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; src_valid = '0;
    src_data = '0; src_rd = '0; src_fp = '0; src_load = '0;
    src_funct3 = '0; src_offset = '0;

    //      src data           rd  fp ld f3      off  wen fwen aligned
    add_vec(0, 32'h0000_1234, 5,  0, 0, 3'b000, 2'd0, 1, 0, 32'h0000_1234);
    add_vec(1, 32'hDEAD_BEEF, 0,  0, 0, 3'b000, 2'd0, 0, 0, 32'hDEAD_BEEF);
    add_vec(1, 32'hDEAD_BEEF, 0,  1, 0, 3'b000, 2'd0, 0, 1, 32'hDEAD_BEEF);
    add_vec(3, 32'h80FF_7F01, 7,  0, 1, 3'b000, 2'd2, 1, 0, 32'hFFFF_FFFF);
    add_vec(2, 32'h80FF_7F01, 8,  0, 1, 3'b100, 2'd3, 1, 0, 32'h0000_0080);
    add_vec(3, 32'h80FF_7F01, 9,  0, 1, 3'b001, 2'd2, 1, 0, 32'hFFFF_80FF);
    add_vec(0, 32'h80FF_7F01, 10, 0, 1, 3'b101, 2'd0, 1, 0, 32'h0000_7F01);
    add_vec(2, 32'h80FF_7F01, 11, 0, 1, 3'b001, 2'd3, 1, 0, 32'hFFFF_80FF);
    add_vec(1, 32'h80FF_7F01, 12, 1, 1, 3'b010, 2'd0, 0, 1, 32'h80FF_7F01);
    add_vec(3, 32'h80FF_7F01, 13, 0, 0, 3'b000, 2'd2, 1, 0, 32'h80FF_7F01);
    add_vec(0, 32'h80FF_7F01, 14, 0, 1, 3'b011, 2'd1, 1, 0, 32'h80FF_7F01);
    add_vec(2, 32'h80FF_7F01, 15, 0, 1, 3'b000, 2'd1, 1, 0, 32'h0000_007F);
    add_vec(1, 32'h80FF_7F01, 16, 0, 1, 3'b100, 2'd0, 1, 0, 32'h0000_0001);

    // Reset values, sampled while reset is held
    #2;
    chk("rst_regwen", wb_regwen, 0);
    chk("rst_fpregwen", wb_fpregwen, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_wdata", wb_wdata, 0);
    chk("rst_busy", wb_busy, 0);
    chk("rst_ready", src_ready, 4'hF);
    step(); step();
    rst_n = 1'b1;

    // All sources requesting continuously: strict 0,1,2,3,... order
    for (int i = 0; i < N_SRC; i++) set_src(i, 32'hA0 + i, 5'(i + 1), 0, 0, 3'b000, 2'd0);
    src_valid = 4'hF;
    step();
    chk("cont_busy", wb_busy, 1);
    chk("cont_first_wen", wb_regwen, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("cont_rd", wb_rd, (k % 4) + 1);
      chk("cont_wdata", wb_wdata, 32'hA0 + (k % 4));
      chk("cont_wen", wb_regwen, 1);
    end

    // Async reset mid-contention (rr_ptr is 2 here)
    rst_n = 1'b0;
    #1;
    chk("arst_wen", wb_regwen, 0);
    chk("arst_rd", wb_rd, 0);
    chk("arst_wdata", wb_wdata, 0);
    chk("arst_busy", wb_busy, 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("arst_accept_wen", wb_regwen, 0);
    step();
    chk("arst_first_rd", wb_rd, 1);
    chk("arst_first_wen", wb_regwen, 1);
    src_valid = '0;
    repeat (5) step();
    chk("drain_busy", wb_busy, 0);

    // Single source streaming one write per cycle
    for (int k = 0; k < 5; k++) begin
      set_src(0, 32'h1234 + k, 5'd5, 0, 0, 3'b000, 2'd0);
      src_valid[0] = 1'b1;
      #1;
      chk("ss_ready", src_ready[0], 1);
      step();
      if (k > 0) begin
        chk("ss_wdata", wb_wdata, 32'h1234 + k - 1);
        chk("ss_wen", wb_regwen, 1);
      end
    end
    src_valid = '0;
    step();
    chk("ss_last_wdata", wb_wdata, 32'h1238);
    chk("ss_last_rd", wb_rd, 5);
    step();
    chk("ss_idle_wen", wb_regwen, 0);
    chk("ss_idle_busy", wb_busy, 0);

    // Vector table: one entry accepted, written on the following edge
    foreach (vq[n]) begin
      src_valid = '0;
      set_src(vq[n].src, vq[n].data, vq[n].rd, vq[n].fp, vq[n].ld, vq[n].f3, vq[n].off);
      src_valid[vq[n].src] = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", n), src_ready[vq[n].src], 1);
      step();
      src_valid = '0;
      step();
      chk($sformatf("v%0d_regwen", n), wb_regwen, vq[n].exp_wen);
      chk($sformatf("v%0d_fpregwen", n), wb_fpregwen, vq[n].exp_fwen);
      chk($sformatf("v%0d_rd", n), wb_rd, vq[n].rd);
      chk($sformatf("v%0d_wdata", n), wb_wdata, vq[n].exp_wdata);
      chk($sformatf("v%0d_ready_after", n), src_ready, 4'hF);
    end

    // Flush with three buffers full
    for (int i = 0; i < 3; i++) set_src(i, 32'h55 + i, 5'(20 + i), 0, 0, 3'b000, 2'd0);
    src_valid = 4'b0111;
    step();
    src_valid = '0;
    chk("fl_busy_before", wb_busy, 1);
    flush = 1'b1;
    #1;
    chk("fl_ready_low", src_ready, 0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_regwen", wb_regwen, 0);
    chk("fl_fpregwen", wb_fpregwen, 0);
    chk("fl_busy", wb_busy, 0);
    chk("fl_ready", src_ready, 4'hF);
    step();
    chk("fl_after_regwen", wb_regwen, 0);
    chk("fl_after_fpregwen", wb_fpregwen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Parametrised writeback stage that merges N_SRC variable-latency result producers (ALU, FPU, memory loads, multi-cycle units) onto the single register-file write port. Each source has a valid/ready handshake and a one-entry holding buffer. A round-robin arbiter drains the buffers into a registered write port. Load results get byte/half extraction and sign/zero extension on the way through. The block sits between the execute/memory producers and the integer/FP register files.

## Interface
- XLEN, 32, datapath width (32 or 64)
- N_SRC, 4, number of source channels (2..8)
- RD_W, 5, destination register index width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all buffered, not-yet-written results
- src_valid  in  N_SRC  per-source result valid
- src_ready  out  N_SRC  per-source accept
- src_data  in  N_SRC*XLEN  result, or raw memory word for loads
- src_rd  in  N_SRC*RD_W  destination register
- src_fp  in  N_SRC  1 = FP register file, 0 = integer
- src_load  in  N_SRC  1 = apply load alignment
- src_funct3  in  N_SRC*3  load funct3 (LB/LH/LW/LBU/LHU)
- src_offset  in  N_SRC*2  load address bits [1:0]
- wb_regwen  out  1  integer write enable
- wb_fpregwen  out  1  FP write enable
- wb_rd  out  RD_W  write index
- wb_wdata  out  XLEN  write data
- wb_busy  out  1  any holding buffer occupied

## Operation
- Per source i: one-entry buffer, buf_v[i] plus captured fields.
- src_ready[i] = !buf_v[i] | grant[i]. Accepting a new entry in the same cycle as the old one is granted reloads the buffer.
- Accept when src_valid[i] & src_ready[i]. Payload must be stable while valid and not ready.
- Arbiter: combinational over buf_v. Round-robin starting at rr_ptr. At most one grant per cycle.
- On grant to i: rr_ptr <= (i+1) mod N_SRC, and buf_v[i] clears unless it is reloaded.
- Output register loads the granted entry's fields. The enable selected by fp is set.
- With no grant, both enables are 0 and wb_rd/wb_wdata hold their last value.
- Integer write to rd = 0: the entry is consumed (granted, buffer freed) but wb_regwen stays 0. FP rd = 0 writes normally.
- Load alignment (sub-module), byte lane = offset:
  - LB/LBU extract the byte at that lane.
  - LH/LHU extract the half selected by offset[1]; offset[0] is ignored.
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
  - LW passes data[31:0], sign-extended when XLEN = 64.
  - Other funct3 values pass the raw word.
- flush: clears every buf_v and forces both enables to 0 on the next edge. It takes priority over accept and grant in that cycle, and src_ready is 0 while flush is high. rr_ptr is unchanged.
- wb_busy = |buf_v.

## Timing
- Reset values: buf_v = 0, rr_ptr = 0, wb_regwen = 0, wb_fpregwen = 0, wb_rd = 0, wb_wdata = 0. src_ready is all-ones after reset.
- Latency: accept at edge t, then written at edge t+1 at the earliest. Enables are visible in the cycle after t+1.
- Throughput: one write per cycle aggregate; one per cycle per source when that source is the only requester.
- Contention: with all N_SRC buffers full, each source is granted once every N_SRC cycles, and none is skipped.
- rr_ptr wraps from N_SRC-1 to 0.
- Reset asserted mid-operation: all buffers are dropped immediately and outputs return to reset values asynchronously.

## Configuration
- WB_LOAD_ALIGN_EN defined: the alignment sub-module is instantiated, and src_load/src_funct3/src_offset take effect.
- WB_LOAD_ALIGN_EN not defined: those inputs are ignored and not buffered, and src_data is written unchanged. Producers must then deliver pre-aligned data.

## Structure
- wb_pkg holds:
  - funct3 constants FNC_LB/LH/LW/LBU/LHU;
  - the buffered-entry struct typedef (data, rd, fp, load, funct3, offset);
  - the round-robin pointer width function, clog2(N_SRC).
- One sub-module, wb_load_align: purely combinational, parameter XLEN; inputs din, funct3, offset, load; output dout. It sits between the granted buffer and the output register.

## Test plan
- Single source 0, data 0x0000_1234, rd 5, integer, accepted at cycle 0 -> wb_regwen = 1, wb_rd = 5, wb_wdata = 0x1234 after edge 1; src_ready[0] stays 1 throughout.
- All 4 sources valid continuously after reset -> grant order 0,1,2,3,0,…; one write per cycle; no source starves.
- Load: raw 0x80FF_7F01, LB offset 2 -> 0xFFFF_FFFF; LBU offset 3 -> 0x0000_0080; LH offset 2 -> 0xFFFF_80FF; LHU offset 0 -> 0x0000_7F01.
- Integer rd = 0, data 0xDEAD_BEEF -> entry consumed, src_ready re-asserts, wb_regwen = 0. The same entry with fp = 1 -> wb_fpregwen = 1, wb_rd = 0.
- Fill three buffers, then assert flush for one cycle -> no enable on the next edge, wb_busy = 0, src_ready all 1 afterwards.
- Deassert rst_n mid-contention -> all outputs 0 immediately; after release, the first grant goes to source 0.
